// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED sequencer and its receive-side checker.
package rgb_pkg;

   typedef enum logic [1:0] {
      BLANK = 2'b00,
      RED   = 2'b01,
      GREEN = 2'b11,
      BLUE  = 2'b10
   } phase_e;

   localparam int RGB_COUNTER_MAX = 10;

   typedef struct packed {
      logic   legal;
      phase_e phase;
   } rgb_sample_t;

   // One-hot (or all-off) colour lines decode to a phase; anything else is illegal.
   function automatic rgb_sample_t decode_rgb(input logic r, input logic g, input logic b);
      rgb_sample_t s;
      s.legal = 1'b1;
      s.phase = BLANK;
      case ({r, g, b})
         3'b000:  s.phase = BLANK;
         3'b100:  s.phase = RED;
         3'b010:  s.phase = GREEN;
         3'b001:  s.phase = BLUE;
         default: s.legal = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/rgb_sequence_checker.sv
// On-chip monitor for the RGB sequencer: checks phase order and dwell time,
// counts completed sequences and raises sticky protocol error flags.
module rgb_sequence_checker
   import rgb_pkg::*;
#(
   parameter int EXP_DWELL = RGB_COUNTER_MAX,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             red,
   input  logic             green,
   input  logic             blue,
   input  logic             clr_err,
   output phase_e           phase,
   output logic             seq_done,
   output logic [CNT_W-1:0] seq_count,
   output logic             err_illegal,
   output logic             err_order,
   output logic             err_dwell,
   output logic             err_pulse
);

   localparam int DW = $clog2(EXP_DWELL + 2);
   localparam logic [DW-1:0] DWELL_EXP = DW'(EXP_DWELL);
   localparam logic [DW-1:0] DWELL_SAT = DW'(EXP_DWELL + 1);

   typedef enum logic [1:0] {S_IDLE, S_RED, S_GREEN, S_BLUE} state_e;

   state_e           r_state;
   phase_e           r_phase;
   logic [DW-1:0]    r_dwell;
   logic             r_seq_clean;
   logic             r_seq_done;
   logic [CNT_W-1:0] r_seq_count;
   logic             r_err_illegal;
   logic             r_err_order;
   logic             r_err_dwell;
   logic             r_err_pulse;

   rgb_sample_t   w_smp;
   state_e        w_state_nxt;
   logic [DW-1:0] w_dwell_nxt;
   logic          w_order_bad;
   logic          w_dwell_bad;
   logic          w_complete;
   logic          w_red_start;
   logic          w_err_any;
   logic          w_done;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      w_smp       = decode_rgb(red, green, blue);
      w_state_nxt = r_state;
      w_order_bad = 1'b0;
      w_complete  = 1'b0;
      w_dwell_nxt = r_dwell;

      // Leaving a colour phase is judged against the last legal phase, whatever the FSM state.
      w_dwell_bad = w_smp.legal && (r_phase != BLANK) && (w_smp.phase != r_phase)
                    && (r_dwell != DWELL_EXP);
      w_red_start = w_smp.legal && (w_smp.phase == RED) && (r_phase != RED);

      if (!w_smp.legal) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_smp.phase == RED)        w_state_nxt = S_RED;
               else if (w_smp.phase != BLANK) w_order_bad = 1'b1;
            end
            S_RED: begin
               if (w_smp.phase == GREEN)    w_state_nxt = S_GREEN;
               else if (w_smp.phase != RED) begin
                  w_order_bad = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_GREEN: begin
               if (w_smp.phase == BLUE)       w_state_nxt = S_BLUE;
               else if (w_smp.phase != GREEN) begin
                  w_order_bad = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               if (w_smp.phase == BLANK) begin
                  w_complete  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (w_smp.phase != BLUE) begin
                  w_order_bad = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         endcase

         if (w_smp.phase == BLANK)        w_dwell_nxt = '0;
         else if (w_smp.phase != r_phase) w_dwell_nxt = DW'(1);
         else if (r_dwell != DWELL_SAT)   w_dwell_nxt = r_dwell + 1'b1;
      end

      w_err_any = !w_smp.legal || w_order_bad || w_dwell_bad;
      w_done    = w_complete && r_seq_clean && !w_err_any;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_phase       <= BLANK;
         r_dwell       <= '0;
         r_seq_clean   <= 1'b0;
         r_seq_done    <= 1'b0;
         r_seq_count   <= '0;
         r_err_illegal <= 1'b0;
         r_err_order   <= 1'b0;
         r_err_dwell   <= 1'b0;
         r_err_pulse   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dwell <= w_dwell_nxt;
         if (w_smp.legal) r_phase <= w_smp.phase;

         // A sequence is clean only if nothing went wrong since its RED phase began.
         if (w_red_start)    r_seq_clean <= !w_err_any;
         else if (w_err_any) r_seq_clean <= 1'b0;

         r_seq_done <= w_done;
         if (w_done && (r_seq_count != '1)) r_seq_count <= r_seq_count + 1'b1;

         r_err_illegal <= !w_smp.legal || (r_err_illegal && !clr_err);
         r_err_order   <= w_order_bad  || (r_err_order   && !clr_err);
         r_err_dwell   <= w_dwell_bad  || (r_err_dwell   && !clr_err);
         r_err_pulse   <= w_err_any;
      end
   end

   assign phase       = r_phase;
   assign seq_done    = r_seq_done;
   assign seq_count   = r_seq_count;
   assign err_illegal = r_err_illegal;
   assign err_order   = r_err_order;
   assign err_dwell   = r_err_dwell;
   assign err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_rgb_sequence_checker.sv
// Scoreboard bench for rgb_sequence_checker: a run-length reference model pushes
// the expected outputs for each sample; a monitor pops and compares after each edge.
module tb_rgb_sequence_checker;
   import rgb_pkg::*;

   localparam int EXP_DWELL = 10;
   localparam int CNT_MAX   = 255;

   logic       clk;
   logic       reset;
   logic       red, green, blue, clr_err;
   phase_e     phase;
   logic       seq_done;
   logic [7:0] seq_count;
   logic       err_illegal, err_order, err_dwell, err_pulse;

   rgb_sequence_checker #(.EXP_DWELL(EXP_DWELL), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .clr_err     (clr_err),
      .phase       (phase),
      .seq_done    (seq_done),
      .seq_count   (seq_count),
      .err_illegal (err_illegal),
      .err_order   (err_order),
      .err_dwell   (err_dwell),
      .err_pulse   (err_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      phase_e ph;
      bit     done;
      int     cnt;
      bit     ill;
      bit     ord;
      bit     dw;
      bit     pulse;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: colour index 0=BLANK 1=RED 2=GREEN 3=BLUE, legal order is index+1 mod 4.
   phase_e PH[4] = '{BLANK, RED, GREEN, BLUE};
   int m_last, m_run, m_pos, m_cnt;
   bit m_clean, m_ill, m_ord, m_dw;

   task automatic model_reset();
      m_last = 0; m_run = 0; m_pos = 0; m_cnt = 0;
      m_clean = 0; m_ill = 0; m_ord = 0; m_dw = 0;
   endtask

   function automatic int colour_of(input logic [2:0] rgb);
      case (rgb)
         3'b000:  return 0;
         3'b100:  return 1;
         3'b010:  return 2;
         3'b001:  return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model(input logic [2:0] rgb, input bit clr);
      int   c;
      bit   e_ill, e_ord, e_dw, wrap, err, done;
      exp_t e;
      c = colour_of(rgb);
      e_ill = (c < 0);
      e_ord = 0; e_dw = 0; wrap = 0;
      if (!e_ill) begin
         if (m_last != 0 && c != m_last && m_run != EXP_DWELL) e_dw = 1;
         if (c != m_pos) begin
            if (c == (m_pos + 1) % 4) begin
               wrap  = (m_pos == 3);
               m_pos = (m_pos + 1) % 4;
            end else begin
               e_ord = 1;
               m_pos = 0;
            end
         end
      end else begin
         m_pos = 0;
      end
      err  = e_ill | e_ord | e_dw;
      done = wrap && m_clean && !err;
      if (!e_ill && c == 1 && m_last != 1) m_clean = !err;
      else if (err)                         m_clean = 0;
      if (!e_ill) begin
         m_run  = (c == 0) ? 0 : (c == m_last) ? m_run + 1 : 1;
         m_last = c;
      end
      if (done && m_cnt < CNT_MAX) m_cnt++;
      m_ill = e_ill | (m_ill & !clr);
      m_ord = e_ord | (m_ord & !clr);
      m_dw  = e_dw  | (m_dw  & !clr);
      e.ph = PH[m_last]; e.done = done; e.cnt = m_cnt;
      e.ill = m_ill; e.ord = m_ord; e.dw = m_dw; e.pulse = err;
      q.push_back(e);
   endtask

   // c: 0..3 colour index, 4 = {1,1,0}, 5 = random multi-line value.
   function automatic logic [2:0] rgb_of(input int c);
      logic [2:0] v;
      case (c)
         0:       v = 3'b000;
         1:       v = 3'b100;
         2:       v = 3'b010;
         3:       v = 3'b001;
         4:       v = 3'b110;
         default: begin
            v = 3'($urandom_range(3, 7));
            if (v == 3'b100) v = 3'b111;
         end
      endcase
      return v;
   endfunction

   task automatic step(input int c, input bit clr);
      logic [2:0] rgb;
      @(negedge clk);
      rgb = rgb_of(c);
      {red, green, blue} = rgb;
      clr_err = clr;
      model(rgb, clr);
   endtask

   task automatic hold(input int c, input int n);
      for (int k = 0; k < n; k++) step(c, 1'b0);
   endtask

   task automatic legal_seq(input int blank_len);
      hold(0, blank_len); hold(1, 10); hold(2, 10); hold(3, 10);
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() != 0 && guard < 8) begin
         @(posedge clk); #2;
         guard++;
      end
      if (q.size() != 0) begin
         check("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   // Monitor: one expected entry per sampled edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            check("phase",       32'(phase),       32'(e.ph));
            check("seq_done",    32'(seq_done),    32'(e.done));
            check("seq_count",   32'(seq_count),   32'(e.cnt));
            check("err_illegal", 32'(err_illegal), 32'(e.ill));
            check("err_order",   32'(err_order),   32'(e.ord));
            check("err_dwell",   32'(err_dwell),   32'(e.dw));
            check("err_pulse",   32'(err_pulse),   32'(e.pulse));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_phase"},   32'(phase),       32'(BLANK));
      check({tag, "_done"},    32'(seq_done),    32'd0);
      check({tag, "_count"},   32'(seq_count),   32'd0);
      check({tag, "_illegal"}, 32'(err_illegal), 32'd0);
      check({tag, "_order"},   32'(err_order),   32'd0);
      check({tag, "_dwell"},   32'(err_dwell),   32'd0);
      check({tag, "_pulse"},   32'(err_pulse),   32'd0);
   endtask

   initial begin
      int cur;
      reset = 1'b0; red = 0; green = 0; blue = 0; clr_err = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 check_all_zero("reset");
      @(posedge clk); #3 reset = 1'b1;

      // Three legal cycles.
      for (int i = 0; i < 3; i++) legal_seq(5);
      hold(0, 5);
      drain();
      check("t1_count", 32'(seq_count), 32'd3);
      check("t1_flags", 32'({err_illegal, err_order, err_dwell}), 32'd0);

      // GREEN one cycle short.
      hold(1, 10); hold(2, 9); hold(3, 10); hold(0, 5);
      drain();
      check("t2_dwell", 32'(err_dwell), 32'd1);
      check("t2_count", 32'(seq_count), 32'd3);

      // RED then straight to BLUE.
      step(0, 1'b1); hold(0, 2); hold(1, 10); hold(3, 1);
      drain();
      check("t3_order", 32'(err_order), 32'd1);
      check("t3_dwell", 32'(err_dwell), 32'd0);
      legal_seq(5); hold(0, 3);
      drain();
      check("t3_count", 32'(seq_count), 32'd4);

      // Illegal sample in the middle of RED.
      step(0, 1'b1); hold(0, 3); hold(1, 5); step(4, 1'b0);
      drain();
      check("t4_illegal", 32'(err_illegal), 32'd1);
      check("t4_phase",   32'(phase),       32'(RED));
      hold(1, 5); hold(2, 10); hold(3, 10); hold(0, 3);
      drain();
      check("t4_count", 32'(seq_count), 32'd4);

      // Clear colliding with a new order error, then clear alone.
      step(0, 1'b1); hold(1, 10); step(0, 1'b1);
      drain();
      check("t5_order_set_wins", 32'(err_order), 32'd1);
      step(0, 1'b1);
      drain();
      check("t5_cleared", 32'({err_illegal, err_order, err_dwell}), 32'd0);

      // Asynchronous reset in the middle of GREEN.
      hold(0, 3); hold(1, 10); hold(2, 4);
      drain();
      @(posedge clk); #2 reset = 1'b0;
      #1 check_all_zero("t6_async");
      model_reset();
      q.delete();
      red = 0; green = 0; blue = 0; clr_err = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      legal_seq(3); hold(0, 3);
      drain();
      check("t6_count", 32'(seq_count), 32'd1);

      // Randomised segments, mostly in legal order with occasional faults.
      cur = 0;
      for (int s = 0; s < 300; s++) begin
         int c;
         int n;
         if ($urandom_range(0, 3) != 0) c = (cur + 1) % 4;
         else                           c = $urandom_range(0, 3);
         if (c == 0)                          n = $urandom_range(1, 4);
         else if ($urandom_range(0, 2) == 0)  n = $urandom_range(8, 11);
         else                                 n = EXP_DWELL;
         if ($urandom_range(0, 19) == 0) step(5, 1'b0);
         for (int k = 0; k < n; k++) step(c, $urandom_range(0, 39) == 0);
         cur = c;
      end
      hold(0, 2);
      drain();

      // Drive the completed-sequence counter into saturation.
      for (int i = 0; i < 260; i++) legal_seq(1);
      hold(0, 2);
      drain();
      check("sat_count", 32'(seq_count), 32'(CNT_MAX));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
